mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It registers the EX-to-MEM bus, extracts and extends load data from the synchronous data SRAM, and produces the MEM-to-WB bus and the MEM-to-ID forwarding bus.
- It holds the SRAM read data across MEM stalls. The synchronous SRAM output is only valid in the first cycle after the request.

Parameters:
- EX_TO_MEM_WD, 146, width of ex_to_mem_bus.
- MEM_TO_WB_WD, 136, width of mem_to_wb_bus.
- MEM_TO_ID_WD, 104, width of mem_to_id_bus.
- STALL_WD, 6, width of stall vector.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- stall  in  STALL_WD  stall vector; bit 3 = MEM, bit 4 = WB; 1 = Stop.
- ex_to_mem_bus  in  146  fields:
  - [145:142] ld_sel
  - [141] hi_we, [140:109] hi
  - [108] lo_we, [107:76] lo
  - [75:44] pc
  - [43] ram_en, [42:39] ram_wen
  - [38] sel_rf_res, [37] rf_we, [36:32] rf_waddr
  - [31:0] ex_result (address or ALU result)
- data_sram_rdata  in  32  SRAM read word, valid the cycle after the EX request.
- mem_to_wb_bus  out  136  {hi_we, hi, lo_we, lo, pc, rf_we, rf_waddr, rf_wdata}, MSB first.
- mem_to_id_bus  out  104  {hi_we, hi, lo_we, lo, rf_we, rf_waddr, rf_wdata}.

Behaviour:
- Reset: async on resetn=0. Clears the bus register, the state machine (to FRESH) and rdata_buf. All outputs are then 0.
- Bus register update, per clock edge:
  - stall[3]=1 and stall[4]=0: load zeros (bubble).
  - else stall[3]=0: capture ex_to_mem_bus.
  - else (stall[3]=1, stall[4]=1): hold.
- Load detect: is_load = ram_en & (ram_wen==4'b0000) & sel_rf_res.
- Read-data state machine (2 states):
  - FRESH: the instruction entered MEM this cycle; the effective word is data_sram_rdata.
    - If stall[3]=1 and stall[4]=1: latch rdata_buf <= data_sram_rdata, go to HELD.
    - Otherwise stay FRESH.
  - HELD: the effective word is rdata_buf.
    - Leave to FRESH on the first edge where stall[3]=0 (new instruction enters) or where a bubble is loaded.
- The state machine latches regardless of is_load; a harmless word is held for non-loads.
- Load extraction. a = ex_result[1:0]; the byte is selected by a, the half by a[1]; a[0] is ignored for halves.
  - ld_sel 4'b1111: lw, whole word.
  - 4'b0001: lb, sign-extended byte.
  - 4'b0010: lbu, zero-extended byte.
  - 4'b0011: lh, sign-extended half.
  - 4'b0100: lhu, zero-extended half.
  - Any other ld_sel: whole word.
  - Byte lanes: a=00 → [7:0], 01 → [15:8], 10 → [23:16], 11 → [31:24]. Half: a[1]=0 → [15:0], 1 → [31:16].
- Write data: rf_wdata = sel_rf_res ? load_data : ex_result.
- Combinational paths: both output buses are combinational from the register, state and rdata, with zero added latency. Buses are all-zero for a bubble.
- Pass-through: hi/lo fields pass unchanged; stores (ram_wen≠0) pass through with rf_we as given.
- Simultaneous events:
  - stall[3] released in the same edge as the HELD exit: the new instruction is FRESH.
  - resetn asserted mid-stall: the held word is discarded.

Test Plan:
- lw to 0x100 with rdata 0xDEADBEEF, no stall → next cycle mem_to_wb_bus rf_wdata=0xDEADBEEF, rf_we=1.
- lb, addr low bits 2'b11, rdata 0x80123456 → rf_wdata=0xFFFFFF80; lbu same → 0x00000080; lh a=10 → 0xFFFF8012; lhu a=00 → 0x00003456.
- lw in MEM, stall=6'b011111 for 3 cycles, rdata changes to 0x0 after cycle 1 → rf_wdata holds original 0x12345678 throughout; on release the next instruction is FRESH.
- stall[3]=1, stall[4]=0 → next cycle both buses are 0 (bubble).
- ALU result 0x55 with sel_rf_res=0, plus hi_we=1, hi=0xA5A5A5A5 → rf_wdata=0x55; hi fields identical on mem_to_wb_bus and mem_to_id_bus.
- resetn pulsed low asynchronously mid-HELD → outputs 0 immediately; after release the first lw reads live data_sram_rdata.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between execute and write-back.
// Registers the EX-to-MEM bus, keeps the synchronous SRAM read word alive
// across MEM stalls, extracts/extends load data and drives the MEM-to-WB
// and MEM-to-ID (forwarding) buses combinationally from the stage register.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 146,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_ID_WD = 104,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    // Field layout of the EX-to-MEM bus, MSB first.
    typedef struct packed {
        logic [3:0]  ld_sel;
        logic        hi_we;
        logic [31:0] hi;
        logic        lo_we;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    // FRESH: SRAM output belongs to the instruction in MEM this cycle.
    // HELD : the word was captured into r_rdata_buf during a stall.
    typedef enum logic {
        FRESH = 1'b0,
        HELD  = 1'b1
    } rd_state_e;

    localparam logic [3:0] LD_LB  = 4'b0001;
    localparam logic [3:0] LD_LBU = 4'b0010;
    localparam logic [3:0] LD_LH  = 4'b0011;
    localparam logic [3:0] LD_LHU = 4'b0100;

    ex_to_mem_t  r_bus;
    rd_state_e   r_state;
    logic [31:0] r_rdata_buf;

    logic        w_mem_stall;
    logic        w_wb_stall;
    logic        w_hold;
    logic        w_bubble;
    logic [31:0] w_rdata;
    logic [1:0]  w_addr_lo;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;
    logic        w_is_load;
    logic        w_unused_ok;

    assign w_mem_stall = stall[3];
    assign w_wb_stall  = stall[4];
    // Both MEM and WB frozen: the instruction in MEM stays put.
    assign w_hold      = w_mem_stall & w_wb_stall;
    // MEM frozen but WB moving on: a bubble is pushed into WB.
    assign w_bubble    = w_mem_stall & ~w_wb_stall;

    // Stage register: bubble, capture or hold depending on the stall vector.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus <= '0;
        end else if (w_bubble) begin
            r_bus <= '0;
        end else if (!w_mem_stall) begin
            // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
            r_bus <= ex_to_mem_bus;
        end
    end

    // Read-data tracker: capture the one-cycle SRAM word when the stage freezes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= FRESH;
            // NOTE: the buffer is a single word, so it is reset with the state; a stale word must never survive reset.
            r_rdata_buf <= '0;
        end else begin
            case (r_state)
                FRESH: begin
                    if (w_hold) begin
                        r_rdata_buf <= data_sram_rdata;
                        r_state     <= HELD;
                    end
                end
                HELD: begin
                    // A new instruction entering or a bubble both end the hold.
                    if (!w_hold) begin
                        r_state <= FRESH;
                    end
                end
                default: r_state <= FRESH;
            endcase
        end
    end

    assign w_rdata   = (r_state == HELD) ? r_rdata_buf : data_sram_rdata;
    assign w_addr_lo = r_bus.ex_result[1:0];

    // Load extraction: pick byte/half lane from the low address bits and extend.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_byte      = w_rdata[7:0];
        w_half      = w_addr_lo[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_load_data = w_rdata;
        case (w_addr_lo)
            2'b00:   w_byte = w_rdata[7:0];
            2'b01:   w_byte = w_rdata[15:8];
            2'b10:   w_byte = w_rdata[23:16];
            2'b11:   w_byte = w_rdata[31:24];
            default: w_byte = w_rdata[7:0];
        endcase
        case (r_bus.ld_sel)
            LD_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  w_load_data = {24'h0, w_byte};
            LD_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  w_load_data = {16'h0, w_half};
            default: w_load_data = w_rdata;
        endcase
    end

    assign w_rf_wdata = r_bus.sel_rf_res ? w_load_data : r_bus.ex_result;

    // Load qualifier kept for reference; write-back selection uses sel_rf_res.
    assign w_is_load   = r_bus.ram_en & (r_bus.ram_wen == 4'b0000) & r_bus.sel_rf_res;
    assign w_unused_ok = ^{stall[5], stall[2:0], w_is_load};

    assign mem_to_wb_bus = {r_bus.hi_we, r_bus.hi, r_bus.lo_we, r_bus.lo,
                            r_bus.pc, r_bus.rf_we, r_bus.rf_waddr, w_rf_wdata};

    assign mem_to_id_bus = {r_bus.hi_we, r_bus.hi, r_bus.lo_we, r_bus.lo,
                            r_bus.rf_we, r_bus.rf_waddr, w_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed tests for mem_stage with hand-computed expectations.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic [5:0]   stall;
    logic [145:0] ex_bus;
    logic [31:0]  rdata;
    logic [135:0] wb_bus;
    logic [103:0] id_bus;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .mem_to_id_bus   (id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [145:0] mk_bus(
        input logic [3:0] ld_sel, input logic hi_we, input logic [31:0] hi,
        input logic lo_we, input logic [31:0] lo, input logic [31:0] pc,
        input logic ram_en, input logic [3:0] ram_wen, input logic sel,
        input logic rf_we, input logic [4:0] waddr, input logic [31:0] res);
        return {ld_sel, hi_we, hi, lo_we, lo, pc, ram_en, ram_wen, sel, rf_we, waddr, res};
    endfunction

    function automatic logic [145:0] ld_bus(input logic [3:0] ld_sel, input logic [31:0] pc,
                                            input logic [4:0] waddr, input logic [31:0] addr);
        return mk_bus(ld_sel, 1'b0, 32'h0, 1'b0, 32'h0, pc, 1'b1, 4'b0000, 1'b1, 1'b1, waddr, addr);
    endfunction

    function automatic logic [135:0] exp_wb(input logic hi_we, input logic [31:0] hi,
        input logic lo_we, input logic [31:0] lo, input logic [31:0] pc,
        input logic rf_we, input logic [4:0] waddr, input logic [31:0] wdata);
        return {hi_we, hi, lo_we, lo, pc, rf_we, waddr, wdata};
    endfunction

    function automatic logic [103:0] exp_id(input logic hi_we, input logic [31:0] hi,
        input logic lo_we, input logic [31:0] lo,
        input logic rf_we, input logic [4:0] waddr, input logic [31:0] wdata);
        return {hi_we, hi, lo_we, lo, rf_we, waddr, wdata};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        stall  = 6'b0;
        ex_bus = ld_bus(4'b1111, 32'h0040_0000, 5'd1, 32'h100);
        rdata  = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (wb_bus !== 136'h0) begin
            n_err++;
            $display("FAIL reset_wb: got %h want 0", wb_bus);
        end
        n_cmp++;
        if (id_bus !== 104'h0) begin
            n_err++;
            $display("FAIL reset_id: got %h want 0", id_bus);
        end
        tick;
        tick;
        n_cmp++;
        if (wb_bus !== 136'h0) begin
            n_err++;
            $display("FAIL reset_held_wb: got %h want 0", wb_bus);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_lw;
        logic [135:0] ewb;
        logic [103:0] eid;
        ex_bus = ld_bus(4'b1111, 32'h0040_0000, 5'd5, 32'h0000_0100);
        stall  = 6'b0;
        rdata  = 32'h0;
        tick;
        rdata = 32'hDEAD_BEEF;
        #1;
        ewb = exp_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'h0040_0000, 1'b1, 5'd5, 32'hDEAD_BEEF);
        eid = exp_id(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        n_cmp++;
        if (wb_bus !== ewb) begin
            n_err++;
            $display("FAIL lw_wb: got %h want %h", wb_bus, ewb);
        end
        n_cmp++;
        if (id_bus !== eid) begin
            n_err++;
            $display("FAIL lw_id: got %h want %h", id_bus, eid);
        end
    endtask

    task automatic test_extract;
        logic [3:0]  sels [9] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0011,
                                  4'b0001, 4'b0100, 4'b0111, 4'b0001};
        logic [31:0] adrs [9] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h103,
                                  32'h101, 32'h102, 32'h100, 32'h102};
        logic [31:0] exps [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012,
                                  32'h0000_3456, 32'hFFFF_8012, 32'h0000_0034,
                                  32'h0000_8012, 32'h8012_3456, 32'h0000_0012};
        stall = 6'b0;
        for (int i = 0; i < 9; i++) begin
            ex_bus = ld_bus(sels[i], 32'h0040_0100 + 32'(i * 4), 5'd10, adrs[i]);
            rdata  = 32'h0;
            tick;
            rdata = 32'h8012_3456;
            #1;
            n_cmp++;
            if (wb_bus[31:0] !== exps[i]) begin
                n_err++;
                $display("FAIL extract_%0d (ld_sel=%b a=%b): got %h want %h",
                         i, sels[i], adrs[i][1:0], wb_bus[31:0], exps[i]);
            end
        end
    endtask

    task automatic test_stall_hold;
        stall  = 6'b0;
        ex_bus = ld_bus(4'b1111, 32'h0040_0010, 5'd7, 32'h200);
        rdata  = 32'h0;
        tick;
        rdata = 32'h1234_5678;
        stall = 6'b011111;
        ex_bus = ld_bus(4'b0010, 32'h0040_0014, 5'd9, 32'h301);
        #1;
        n_cmp++;
        if (wb_bus[31:0] !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL stall_c1: got %h want 12345678", wb_bus[31:0]);
        end
        tick;
        rdata = 32'h0;
        #1;
        n_cmp++;
        if (wb_bus[31:0] !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL stall_c2: got %h want 12345678", wb_bus[31:0]);
        end
        n_cmp++;
        if (wb_bus[36:32] !== 5'd7) begin
            n_err++;
            $display("FAIL stall_waddr: got %0d want 7", wb_bus[36:32]);
        end
        tick;
        n_cmp++;
        if (wb_bus[31:0] !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL stall_c3: got %h want 12345678", wb_bus[31:0]);
        end
        stall = 6'b0;
        #1;
        n_cmp++;
        if (id_bus[31:0] !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL stall_release_pre: got %h want 12345678", id_bus[31:0]);
        end
        tick;
        rdata = 32'hAABB_CCDD;
        #1;
        n_cmp++;
        if (wb_bus[31:0] !== 32'h0000_00CC) begin
            n_err++;
            $display("FAIL stall_next_fresh: got %h want 000000cc", wb_bus[31:0]);
        end
        n_cmp++;
        if (wb_bus[36:32] !== 5'd9) begin
            n_err++;
            $display("FAIL stall_next_waddr: got %0d want 9", wb_bus[36:32]);
        end
    endtask

    task automatic test_bubble;
        stall  = 6'b0;
        ex_bus = ld_bus(4'b1111, 32'h0040_0020, 5'd3, 32'h400);
        tick;
        rdata = 32'h1111_2222;
        stall = 6'b001000;
        tick;
        n_cmp++;
        if (wb_bus !== 136'h0) begin
            n_err++;
            $display("FAIL bubble_wb: got %h want 0", wb_bus);
        end
        n_cmp++;
        if (id_bus !== 104'h0) begin
            n_err++;
            $display("FAIL bubble_id: got %h want 0", id_bus);
        end
        // Enter HELD, then leave it through a bubble.
        stall  = 6'b0;
        ex_bus = ld_bus(4'b1111, 32'h0040_0024, 5'd3, 32'h404);
        tick;
        rdata = 32'h3333_4444;
        stall = 6'b011000;
        tick;
        rdata = 32'h0;
        #1;
        n_cmp++;
        if (wb_bus[31:0] !== 32'h3333_4444) begin
            n_err++;
            $display("FAIL bubble_pre_held: got %h want 33334444", wb_bus[31:0]);
        end
        stall = 6'b001000;
        tick;
        n_cmp++;
        if (wb_bus !== 136'h0) begin
            n_err++;
            $display("FAIL bubble_from_held: got %h want 0", wb_bus);
        end
        stall  = 6'b0;
        ex_bus = ld_bus(4'b1111, 32'h0040_0028, 5'd8, 32'h500);
        tick;
        rdata = 32'h5A5A_0F0F;
        #1;
        n_cmp++;
        if (wb_bus[31:0] !== 32'h5A5A_0F0F) begin
            n_err++;
            $display("FAIL bubble_after_fresh: got %h want 5a5a0f0f", wb_bus[31:0]);
        end
    endtask

    task automatic test_alu_hilo;
        logic [135:0] ewb;
        logic [103:0] eid;
        stall  = 6'b0;
        ex_bus = mk_bus(4'b0000, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h1357_9BDF, 32'h0040_0030,
                        1'b0, 4'b0000, 1'b0, 1'b1, 5'd2, 32'h0000_0055);
        tick;
        rdata = 32'hFFFF_FFFF;
        #1;
        ewb = exp_wb(1'b1, 32'hA5A5_A5A5, 1'b0, 32'h1357_9BDF, 32'h0040_0030, 1'b1, 5'd2, 32'h55);
        eid = exp_id(1'b1, 32'hA5A5_A5A5, 1'b0, 32'h1357_9BDF, 1'b1, 5'd2, 32'h55);
        n_cmp++;
        if (wb_bus !== ewb) begin
            n_err++;
            $display("FAIL alu_wb: got %h want %h", wb_bus, ewb);
        end
        n_cmp++;
        if (id_bus !== eid) begin
            n_err++;
            $display("FAIL alu_id: got %h want %h", id_bus, eid);
        end
        // Store: address passes as rf_wdata, rf_we kept as given.
        ex_bus = mk_bus(4'b0000, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, 32'h0040_0034,
                        1'b1, 4'b1111, 1'b0, 1'b0, 5'd0, 32'h0000_0600);
        tick;
        #1;
        ewb = exp_wb(1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, 32'h0040_0034, 1'b0, 5'd0, 32'h600);
        n_cmp++;
        if (wb_bus !== ewb) begin
            n_err++;
            $display("FAIL store_wb: got %h want %h", wb_bus, ewb);
        end
    endtask

    task automatic test_reset_mid_held;
        stall  = 6'b0;
        ex_bus = ld_bus(4'b1111, 32'h0040_0040, 5'd4, 32'h700);
        tick;
        rdata = 32'hCAFE_F00D;
        stall = 6'b011111;
        tick;
        rdata = 32'h0;
        #1;
        n_cmp++;
        if (wb_bus[31:0] !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL rst_pre_held: got %h want cafef00d", wb_bus[31:0]);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (wb_bus !== 136'h0) begin
            n_err++;
            $display("FAIL rst_async_wb: got %h want 0", wb_bus);
        end
        n_cmp++;
        if (id_bus !== 104'h0) begin
            n_err++;
            $display("FAIL rst_async_id: got %h want 0", id_bus);
        end
        @(negedge clk);
        resetn = 1'b1;
        stall  = 6'b0;
        ex_bus = ld_bus(4'b1111, 32'h0040_0044, 5'd6, 32'h704);
        tick;
        rdata = 32'h0BAD_C0DE;
        #1;
        n_cmp++;
        if (wb_bus[31:0] !== 32'h0BAD_C0DE) begin
            n_err++;
            $display("FAIL rst_first_lw: got %h want 0badc0de", wb_bus[31:0]);
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_extract;
        test_stall_hold;
        test_bubble;
        test_alu_hilo;
        test_reset_mid_held;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
